// File: rtl/alg_pkg.sv
// -----------------------------------------------------------------------------
// alg_pkg
// Shared definitions for the RR statistics datapath.
//   state_t       : control states of rr_stats
//   bpm_dividend  : 60 * sample rate, the numerator of the heart-rate division
// -----------------------------------------------------------------------------
package alg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_AVG,
        ST_DIVIDE,
        ST_DONE
    } state_t;

    // Samples per minute: dividing this by an RR interval in samples gives bpm.
    function automatic int unsigned bpm_dividend(input int unsigned fs_hz);
        return 60 * fs_hz;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per enabled cycle, WIDTH cycles.
//   clk      : clock, rising edge
//   nrst     : asynchronous active-low reset
//   ce       : clock enable, all state holds when low
//   start    : loads dividend/divisor (sampled when ce=1)
//   dividend : numerator
//   divisor  : denominator, must be non-zero
//   done     : high in the enabled cycle that resolves the final bit
//   quotient : full quotient, valid while done is high
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             ce,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] dvs_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [WIDTH:0]   rem_shift;

    // The dividend is shifted out of quo_reg MSB-first while quotient bits
    // shift in at the bottom, so after WIDTH steps quo_reg holds the quotient.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        if (rem_shift >= {1'b0, dvs_reg}) begin
            rem_next = WIDTH'(rem_shift - {1'b0, dvs_reg});
            quo_next = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (ce) begin
            if (start) begin
                rem_reg  <= '0;
                quo_reg  <= dividend;
                dvs_reg  <= divisor;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                rem_reg <= rem_next;
                quo_reg <= quo_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_STEP) begin
                    busy_reg <= 1'b0;
                end
            end
        end
    end

    // The quotient is presented from the combinational step so the consumer
    // can register it on the same edge that resolves the last bit.
    assign done     = busy_reg & ce & (cnt_reg == LAST_STEP);
    assign quotient = quo_next;

endmodule

// File: rtl/rr_stats.sv
// -----------------------------------------------------------------------------
// rr_stats
// Moving average of the last NAVG RR intervals, heart rate in bpm and
// brady/tachy alarms.
//   i_clk               : clock, rising edge
//   i_nrst              : asynchronous active-low reset
//   i_ce                : clock enable, all state holds when low
//   i_rr_period         : RR interval in samples
//   i_rr_period_updated : one-cycle pulse qualifying i_rr_period
//   o_rr_avg            : mean of the last NAVG intervals
//   o_hr_bpm            : heart rate, saturated to all ones
//   o_hr_valid          : one-cycle pulse marking new o_hr_bpm / o_rr_avg
//   o_brady, o_tachy    : rate alarm levels, updated with o_hr_valid
//   o_busy              : processing an update
//   o_overrun           : sticky, a pending update was overwritten
// -----------------------------------------------------------------------------
module rr_stats
    import alg_pkg::*;
#(
    parameter int CTR_WIDTH = 22,
    parameter int NAVG      = 8,
    parameter int FS_HZ     = 360,
    parameter int HR_WIDTH  = 8,
    parameter int BRADY_BPM = 50,
    parameter int TACHY_BPM = 120
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_ce,
    input  logic [CTR_WIDTH-1:0] i_rr_period,
    input  logic                 i_rr_period_updated,
    output logic [CTR_WIDTH-1:0] o_rr_avg,
    output logic [HR_WIDTH-1:0]  o_hr_bpm,
    output logic                 o_hr_valid,
    output logic                 o_brady,
    output logic                 o_tachy,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int LOG_N  = $clog2(NAVG);
    localparam int SUM_W  = CTR_WIDTH + LOG_N;
    localparam int FILL_W = $clog2(NAVG + 1);
    localparam int DCNT_W = $clog2(CTR_WIDTH);

    localparam logic [CTR_WIDTH-1:0] DIVIDEND  = CTR_WIDTH'(bpm_dividend(FS_HZ));
    localparam logic [HR_WIDTH-1:0]  HR_MAX    = '1;
    localparam logic [CTR_WIDTH-1:0] HR_MAX_W  = CTR_WIDTH'(HR_MAX);
    localparam logic [HR_WIDTH-1:0]  BRADY_L   = HR_WIDTH'(BRADY_BPM);
    localparam logic [HR_WIDTH-1:0]  TACHY_L   = HR_WIDTH'(TACHY_BPM);
    localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(NAVG);
    localparam logic [DCNT_W-1:0]    DCNT_LAST = DCNT_W'(CTR_WIDTH - 1);

    state_t state_reg;
    state_t state_next;

    logic [CTR_WIDTH-1:0] ring [NAVG];
    logic [CTR_WIDTH-1:0] evict_reg;
    logic [CTR_WIDTH-1:0] cur_reg;
    logic [SUM_W-1:0]     sum_reg;
    logic [LOG_N-1:0]     ptr_reg;
    logic [FILL_W-1:0]    fill_reg;
    logic                 pend_valid_reg;
    logic [CTR_WIDTH-1:0] pend_data_reg;
    logic                 overrun_reg;
    logic [CTR_WIDTH-1:0] avg_work_reg;
    logic                 avg_zero_reg;
    logic [DCNT_W-1:0]    dcnt_reg;
    logic [CTR_WIDTH-1:0] rr_avg_reg;
    logic [HR_WIDTH-1:0]  hr_reg;
    logic                 brady_reg;
    logic                 tachy_reg;

    logic                 update;
    logic                 idle_en;
    logic                 accept;
    logic                 full_now;
    logic [FILL_W-1:0]    fill_inc;
    logic [SUM_W-1:0]     sum_next;
    logic [CTR_WIDTH-1:0] avg_next;
    logic                 div_start;
    logic                 div_done;
    logic                 div_last;
    logic [CTR_WIDTH-1:0] div_quotient;
    logic [HR_WIDTH-1:0]  hr_calc;

    assign update   = i_ce & i_rr_period_updated;
    assign idle_en  = i_ce & (state_reg == ST_IDLE);
    assign accept   = idle_en & (pend_valid_reg | i_rr_period_updated);
    assign full_now = (fill_reg == FILL_FULL);
    assign fill_inc = full_now ? fill_reg : fill_reg + FILL_W'(1);

    // Until the ring is full the slot being overwritten holds nothing real,
    // so the evicted value counts as zero.
    assign sum_next = sum_reg + SUM_W'(cur_reg) - (full_now ? SUM_W'(evict_reg) : '0);
    assign avg_next = sum_reg[SUM_W-1:LOG_N];

    // A zero average skips the divider but still spends CTR_WIDTH cycles in
    // DIVIDE so the result latency does not depend on the data.
    assign div_start = i_ce & (state_reg == ST_AVG) & (avg_next != '0);
    assign div_last  = avg_zero_reg ? (i_ce & (dcnt_reg == DCNT_LAST)) : div_done;
    assign hr_calc   = (avg_zero_reg || (div_quotient > HR_MAX_W)) ? HR_MAX
                                                                   : div_quotient[HR_WIDTH-1:0];

    seq_divider #(
        .WIDTH (CTR_WIDTH)
    ) u_div (
        .clk      (i_clk),
        .nrst     (i_nrst),
        .ce       (i_ce),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (avg_next),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        o_busy     = (state_reg != ST_IDLE);
        o_hr_valid = 1'b0;
        if (i_ce) begin
            case (state_reg)
                ST_IDLE: begin
                    if (pend_valid_reg || i_rr_period_updated) begin
                        state_next = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    state_next = (fill_inc == FILL_FULL) ? ST_AVG : ST_IDLE;
                end
                ST_AVG: begin
                    state_next = ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (div_last) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                    o_hr_valid = 1'b1;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Ring storage with registered read; the evicted entry is fetched in the
    // accept cycle so it is ready when ACCUM updates the sum.
    always_ff @(posedge i_clk) begin
        if (i_ce && state_reg == ST_ACCUM) begin
            ring[ptr_reg] <= cur_reg;
        end
        if (accept) begin
            evict_reg <= ring[ptr_reg];
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cur_reg        <= '0;
            sum_reg        <= '0;
            ptr_reg        <= '0;
            fill_reg       <= '0;
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= '0;
            overrun_reg    <= 1'b0;
            avg_work_reg   <= '0;
            avg_zero_reg   <= 1'b0;
            dcnt_reg       <= '0;
            rr_avg_reg     <= '0;
            hr_reg         <= '0;
            brady_reg      <= 1'b0;
            tachy_reg      <= 1'b0;
        end else if (i_ce) begin
            // Pending entry takes priority in IDLE; a simultaneous new update
            // refills the slot just vacated, so nothing is lost.
            if (state_reg == ST_IDLE) begin
                if (pend_valid_reg) begin
                    cur_reg        <= pend_data_reg;
                    pend_valid_reg <= i_rr_period_updated;
                    if (i_rr_period_updated) begin
                        pend_data_reg <= i_rr_period;
                    end
                end else if (i_rr_period_updated) begin
                    cur_reg <= i_rr_period;
                end
            end else if (update) begin
                pend_valid_reg <= 1'b1;
                pend_data_reg  <= i_rr_period;
                if (pend_valid_reg) begin
                    overrun_reg <= 1'b1;
                end
            end

            case (state_reg)
                ST_ACCUM: begin
                    sum_reg  <= sum_next;
                    fill_reg <= fill_inc;
                    ptr_reg  <= ptr_reg + LOG_N'(1);
                end
                ST_AVG: begin
                    avg_work_reg <= avg_next;
                    avg_zero_reg <= (avg_next == '0);
                    dcnt_reg     <= '0;
                end
                ST_DIVIDE: begin
                    dcnt_reg <= dcnt_reg + DCNT_W'(1);
                    if (div_last) begin
                        rr_avg_reg <= avg_work_reg;
                        hr_reg     <= hr_calc;
                        brady_reg  <= (hr_calc < BRADY_L);
                        tachy_reg  <= (hr_calc > TACHY_L);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rr_avg  = rr_avg_reg;
    assign o_hr_bpm  = hr_reg;
    assign o_brady   = brady_reg;
    assign o_tachy   = tachy_reg;
    assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_rr_stats.sv
// -----------------------------------------------------------------------------
// tb_rr_stats
// Scoreboard bench for rr_stats. The driver steps a transaction-level model
// (history queue, busy countdown, pending slot) and queues expected results;
// the monitor pops and compares on every o_hr_valid.
// -----------------------------------------------------------------------------
module tb_rr_stats;

    localparam int W    = 22;
    localparam int NAVG = 8;
    localparam int FS   = 360;
    localparam int HRW  = 8;
    localparam int BR   = 50;
    localparam int TA   = 120;
    localparam int LAT  = W + 3;

    typedef struct {
        int avg;
        int bpm;
        bit brady;
        bit tachy;
        int due;
    } exp_t;

    logic           i_clk = 1'b0;
    logic           i_nrst = 1'b0;
    logic           i_ce = 1'b0;
    logic [W-1:0]   i_rr_period = '0;
    logic           i_rr_period_updated = 1'b0;
    logic [W-1:0]   o_rr_avg;
    logic [HRW-1:0] o_hr_bpm;
    logic           o_hr_valid;
    logic           o_brady;
    logic           o_tachy;
    logic           o_busy;
    logic           o_overrun;

    int   checks = 0;
    int   errors = 0;

    int   hist[$];
    exp_t expq[$];
    int   busy_left = 0;
    bit   pend = 0;
    int   pend_val = 0;
    bit   ovr = 0;
    int   en_cnt = 0;
    bit   snap_busy = 0;
    bit   snap_ovr = 0;

    rr_stats #(
        .CTR_WIDTH (W),
        .NAVG      (NAVG),
        .FS_HZ     (FS),
        .HR_WIDTH  (HRW),
        .BRADY_BPM (BR),
        .TACHY_BPM (TA)
    ) dut (
        .i_clk               (i_clk),
        .i_nrst              (i_nrst),
        .i_ce                (i_ce),
        .i_rr_period         (i_rr_period),
        .i_rr_period_updated (i_rr_period_updated),
        .o_rr_avg            (o_rr_avg),
        .o_hr_bpm            (o_hr_bpm),
        .o_hr_valid          (o_hr_valid),
        .o_brady             (o_brady),
        .o_tachy             (o_tachy),
        .o_busy              (o_busy),
        .o_overrun           (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // An accepted period enters the history; once NAVG periods are present a
    // result is due LAT enabled cycles later and the block stays busy until then.
    task automatic model_start(input int p);
        exp_t e;
        int   s;
        int   q;
        hist.push_back(p);
        if (hist.size() > NAVG) void'(hist.pop_front());
        if (hist.size() == NAVG) begin
            s = 0;
            foreach (hist[k]) s += hist[k];
            e.avg = s / NAVG;
            if (e.avg == 0) begin
                e.bpm = 255;
            end else begin
                q = (60 * FS) / e.avg;
                e.bpm = (q > 255) ? 255 : q;
            end
            e.brady = (e.bpm < BR);
            e.tachy = (e.bpm > TA);
            e.due   = en_cnt + LAT;
            expq.push_back(e);
            busy_left = LAT;
        end else begin
            busy_left = 1;
        end
    endtask

    task automatic model_step(input bit upd, input int val);
        if (busy_left == 0) begin
            if (pend) begin
                model_start(pend_val);
                pend = upd;
                if (upd) pend_val = val;
            end else if (upd) begin
                model_start(val);
            end
        end else begin
            busy_left--;
            if (upd) begin
                if (pend) ovr = 1;
                pend = 1;
                pend_val = val;
            end
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge.
    task automatic cyc(input bit ce, input bit upd, input int val);
        @(negedge i_clk);
        snap_busy = (busy_left > 0);
        snap_ovr  = ovr;
        i_ce = ce;
        i_rr_period_updated = upd;
        i_rr_period = W'(val);
        if (ce) begin
            en_cnt++;
            model_step(upd, val);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((busy_left > 0 || pend) && n < max_cyc) begin
            cyc(1'b1, 1'b0, 0);
            n++;
        end
        if (busy_left > 0 || pend) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
        end
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
    endtask

    task automatic send(input int val);
        cyc(1'b1, 1'b1, val);
        wait_idle(200);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_nrst = 1'b0;
        i_ce = 1'b0;
        i_rr_period_updated = 1'b0;
        hist.delete();
        expq.delete();
        busy_left = 0;
        pend = 0;
        ovr = 0;
        snap_busy = 0;
        snap_ovr = 0;
        repeat (3) @(negedge i_clk);
        i_nrst = 1'b1;
    endtask

    // Monitor: samples 1 time unit after the falling edge, after the driver.
    initial begin
        exp_t e;
        exp_t last;
        last = '{0, 0, 0, 0, 0};
        forever begin
            @(negedge i_clk);
            #1;
            if (!i_nrst) last = '{0, 0, 0, 0, 0};
            if (o_hr_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got o_hr_valid=1, expected 0 (t=%0t)", $time);
                end else begin
                    e = expq.pop_front();
                    $display("result: rr_avg=%0d hr_bpm=%0d brady=%0b tachy=%0b cycle=%0d",
                             o_rr_avg, o_hr_bpm, o_brady, o_tachy, en_cnt);
                    chk("rr_avg", 64'(o_rr_avg), 64'(e.avg));
                    chk("hr_bpm", 64'(o_hr_bpm), 64'(e.bpm));
                    chk("brady", 64'(o_brady), 64'(e.brady));
                    chk("tachy", 64'(o_tachy), 64'(e.tachy));
                    chk("latency", 64'(en_cnt), 64'(e.due));
                    last = e;
                end
            end else if (expq.size() > 0 && en_cnt > expq[0].due) begin
                e = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_valid: got no o_hr_valid by cycle %0d, expected at %0d",
                         en_cnt, e.due);
            end
            chk("busy", 64'(o_busy), 64'(snap_busy));
            chk("overrun", 64'(o_overrun), 64'(snap_ovr));
            if (!snap_busy) begin
                chk("hold_rr_avg", 64'(o_rr_avg), 64'(last.avg));
                chk("hold_hr_bpm", 64'(o_hr_bpm), 64'(last.bpm));
                chk("hold_brady", 64'(o_brady), 64'(last.brady));
                chk("hold_tachy", 64'(o_tachy), 64'(last.tachy));
            end
        end
    end

    initial begin
        int v;
        do_reset();
        repeat (2) cyc(1'b1, 1'b0, 0);

        // Fill: only the eighth update yields a result.
        for (int i = 0; i < NAVG; i++) send(360);
        // Rate changes through tachy, brady and saturation.
        for (int i = 0; i < NAVG; i++) send(150);
        for (int i = 0; i < NAVG; i++) send(480);
        for (int i = 0; i < NAVG; i++) send(50);
        for (int i = 0; i < NAVG; i++) send(0);
        for (int i = 0; i < NAVG; i++) send(360);

        // Three updates two cycles apart while busy: overrun, last one wins.
        cyc(1'b1, 1'b1, 200);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 0);
            cyc(1'b1, 1'b1, 300 + 40 * k);
        end
        wait_idle(200);

        // Clock enable toggling during processing, with ignored pulses while low.
        cyc(1'b1, 1'b1, 400);
        for (int k = 0; k < 200 && busy_left > 0; k++) begin
            cyc(k[0], ~k[0], 777);
        end
        wait_idle(200);

        // Reset in the middle of DIVIDE, then a fresh fill.
        cyc(1'b1, 1'b1, 250);
        repeat (10) cyc(1'b1, 1'b0, 0);
        do_reset();
        repeat (2) cyc(1'b1, 1'b0, 0);
        for (int i = 0; i < NAVG; i++) send(300);

        // Random traffic: gated clock, bursts that land while busy.
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60))
                                            : int'($urandom_range(100, 900));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, v);
        end
        wait_idle(400);
        repeat (3) cyc(1'b1, 1'b0, 0);

        chk("results_drained", 64'(expq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
